tree_spawn_controller: RTL and testbench
========================================

// Module: tree_spawn_controller
// PURPOSE
//  Drives the horizontal placement and visibility of a falling tree object.
//  Consumes the object's edgeCollide (left the bottom of the screen) and startOfFrame.
//  Picks a pseudo-random new topLeftX from a free-running LFSR and holds the object hidden for a programmable frame delay.
//  Counts trees that passed; sits between the game controller and the tree object / drawing mux.
// PARAMETERS
//  SCREEN_WIDTH          640      visible X pixels
//  OBJECT_WIDTH_X        100      tree width; must match the tree object
//  INIT_X                270      topLeftX after reset
//  RESPAWN_DELAY_FRAMES  30       frames hidden between collide and respawn (0 = immediate)
//  LFSR_SEED             16'hACE1 LFSR reset value; must be nonzero
//  SCORE_WIDTH           8        width of treesPassed
// PORTS
//  clk           in   1            system clock
//  resetN        in   1            synchronous active-low reset
//  startOfFrame  in   1            one-cycle pulse per VGA frame
//  edgeCollide   in   1            one-cycle pulse from tree object: left bottom edge
//  enable        in   1            game running; low = park controller
//  topLeftX      out  11 (signed)  tree X position to object
//  objectActive  out  1            gate for tree drawingRequest in mux
//  respawnPulse  out  1            one-cycle pulse when tree becomes active again
//  treesPassed   out  SCORE_WIDTH  saturating count of completed falls
// BEHAVIOUR
//  - All registers update on posedge clk; resetN low at a clock edge sets:
//    state=IDLE, topLeftX=INIT_X, objectActive=0, respawnPulse=0, treesPassed=0, delayCnt=0, lfsr=LFSR_SEED.
//  - Reset mid-operation (any state) has the same effect; no pending respawn survives it.
//  - LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11, advances every cycle incl. IDLE.
//    If the value ever reads 0, it reloads LFSR_SEED next cycle.
//  - Position calc: MAX_X = SCREEN_WIDTH-OBJECT_WIDTH_X-1 (539 default); cand = lfsr[9:0].
//    newX = (cand>MAX_X) ? cand-(MAX_X+1) : cand; result always in 0..MAX_X.
//    Requires 2*(MAX_X+1) >= 1024; otherwise newX is clamped to MAX_X.
//  - FSM states: IDLE, ACTIVE, WAIT_RESPAWN. Transitions registered, one-cycle latency.
//  - IDLE: objectActive=0. enable=1 -> ACTIVE next cycle, objectActive=1, respawnPulse=0.
//  - ACTIVE + edgeCollide=1 (enable=1), next cycle:
//    topLeftX=newX (from current lfsr); treesPassed+1 (saturates at all-ones).
//    If RESPAWN_DELAY_FRAMES>0: state=WAIT_RESPAWN, objectActive=0, delayCnt=RESPAWN_DELAY_FRAMES.
//    If 0: stay ACTIVE, objectActive=1, respawnPulse=1.
//  - A startOfFrame in the same cycle as edgeCollide does not count toward the delay.
//  - WAIT_RESPAWN, on each startOfFrame: delayCnt-1. When delayCnt==1 at a startOfFrame:
//    next cycle state=ACTIVE, objectActive=1, respawnPulse=1. Exactly RESPAWN_DELAY_FRAMES frames hidden.
//  - edgeCollide in IDLE or WAIT_RESPAWN: ignored (no score, no X change).
//  - enable=0 in any state, next cycle: state=IDLE, objectActive=0, delayCnt=0, topLeftX held.
//    enable=0 beats a simultaneous edgeCollide (no score increment).
//  - respawnPulse high for exactly one cycle per respawn; 0 otherwise.
// CONFIGURATION
//  TREE_SPAWN_SCORE_EN defined:   treesPassed counter built, behaves as above.
//  TREE_SPAWN_SCORE_EN undefined: no counter logic; treesPassed tied to 0. All other behaviour identical.
// TESTING
//  1 Reset, enable=1 -> after 1 cycle objectActive=1, topLeftX=270, treesPassed=0, respawnPulse=0.
//  2 ACTIVE, pulse edgeCollide -> next cycle objectActive=0, treesPassed=1, topLeftX=model(lfsr) in 0..539.
//    Then 29 startOfFrame: still hidden; 30th -> objectActive=1, respawnPulse=1 for 1 cycle.
//  3 RESPAWN_DELAY_FRAMES=0, edgeCollide -> next cycle objectActive stays 1, respawnPulse=1, new X.
//  4 In WAIT_RESPAWN: edgeCollide ignored (treesPassed unchanged).
//    enable=0 with edgeCollide -> IDLE, no increment. resetN=0 mid-wait -> all reset values.
//  5 Run 300 collides with delay 0 -> treesPassed=255 (saturated), every topLeftX <= 539.
//    Build without TREE_SPAWN_SCORE_EN -> treesPassed=0 throughout.
//  6 Force lfsr=0 via hierarchical deposit -> next cycle lfsr=16'hACE1.

Source files
------------

// File: rtl/tree_spawn_if.sv
// tree_spawn_if: bundles the frame/collision inputs and the placement and
// visibility outputs exchanged between the tree spawn controller and the
// game controller / tree object / drawing mux.
//   master : the spawn controller (drives position, visibility, score)
//   slave  : the surrounding game logic (drives frame, collide, enable)
interface tree_spawn_if #(
    parameter int SCORE_WIDTH = 8
);
    logic                   startOfFrame;
    logic                   edgeCollide;
    logic                   enable;
    logic signed [10:0]     topLeftX;
    logic                   objectActive;
    logic                   respawnPulse;
    logic [SCORE_WIDTH-1:0] treesPassed;

    modport master (
        input  startOfFrame,
        input  edgeCollide,
        input  enable,
        output topLeftX,
        output objectActive,
        output respawnPulse,
        output treesPassed
    );

    modport slave (
        output startOfFrame,
        output edgeCollide,
        output enable,
        input  topLeftX,
        input  objectActive,
        input  respawnPulse,
        input  treesPassed
    );
endinterface

// File: rtl/tree_spawn_controller.sv
// tree_spawn_controller: places a falling tree at a pseudo-random X after it
// leaves the bottom of the screen, keeps it hidden for a programmable number
// of frames, and counts completed falls.
//
// Optional feature macro: TREE_SPAWN_SCORE_EN
//   defined   -> saturating treesPassed counter is built
//   undefined -> no counter logic, treesPassed is tied to zero
module tree_spawn_controller #(
    parameter int          SCREEN_WIDTH         = 640,
    parameter int          OBJECT_WIDTH_X       = 100,
    parameter int          INIT_X               = 270,
    parameter int          RESPAWN_DELAY_FRAMES = 30,
    parameter logic [15:0] LFSR_SEED            = 16'hACE1,
    parameter int          SCORE_WIDTH          = 8
) (
    input  logic          clk,
    input  logic          resetN,
    tree_spawn_if.master  bus
);

    // Rightmost legal left edge so the whole tree stays on screen.
    localparam int MAX_X = SCREEN_WIDTH - OBJECT_WIDTH_X - 1;

    // Delay counter only needs to hold RESPAWN_DELAY_FRAMES; keep at least 1 bit.
    localparam int DCW = (RESPAWN_DELAY_FRAMES > 0) ? $clog2(RESPAWN_DELAY_FRAMES + 1) : 1;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 (right-shifting form).
    localparam logic [15:0] TAP_MASK = 16'hB400;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        ACTIVE       = 2'd1,
        WAIT_RESPAWN = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [10:0]      x_reg, x_next;
    logic             active_reg, active_next;
    logic             pulse_reg, pulse_next;
    logic [DCW-1:0]   delay_reg, delay_next;
    logic [15:0]      lfsr_reg, lfsr_next;
    logic [15:0]      lfsr_step;

    logic [10:0]      cand;
    logic [10:0]      wrapped_x;
    logic [10:0]      new_x;
    logic             collide_taken;

    // ------------------------------------------------------------------
    // LFSR: one Galois shift per cycle; each bit takes its upper neighbour,
    // XORed with the outgoing LSB where the polynomial has a tap.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 16; gi++) begin : g_lfsr_bit
        if (gi == 15) begin : g_top
            assign lfsr_step[gi] = lfsr_reg[0] & TAP_MASK[gi];
        end else begin : g_mid
            assign lfsr_step[gi] = lfsr_reg[gi+1] ^ (lfsr_reg[0] & TAP_MASK[gi]);
        end
    end

    // An all-zero LFSR would lock up, so a zero value reloads the seed.
    always_comb begin
        lfsr_next = lfsr_step;
        if (lfsr_reg == 16'h0000) begin
            lfsr_next = LFSR_SEED;
        end
    end

    // ------------------------------------------------------------------
    // Position: fold the 10-bit candidate into 0..MAX_X with a single
    // subtraction; anything still out of range (only possible for narrow
    // playfields) is clamped to the right edge.
    // ------------------------------------------------------------------
    assign cand = {1'b0, lfsr_reg[9:0]};

    // Wrap-then-clamp of the LFSR candidate into the legal X range.
    always_comb begin
        wrapped_x = cand;
        if (cand > 11'(MAX_X)) begin
            wrapped_x = cand - 11'(MAX_X + 1);
        end
        new_x = wrapped_x;
        if (wrapped_x > 11'(MAX_X)) begin
            new_x = 11'(MAX_X);
        end
    end

    // A collision only counts while the tree is live and the game runs;
    // a simultaneous disable wins.
    assign collide_taken = bus.enable && (state_reg == ACTIVE) && bus.edgeCollide;

    // ------------------------------------------------------------------
    // FSM next-state and next-output logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        x_next      = x_reg;
        active_next = active_reg;
        pulse_next  = 1'b0;
        delay_next  = delay_reg;

        if (!bus.enable) begin
            // Park: hide the tree and drop any pending respawn, keep X.
            state_next  = IDLE;
            active_next = 1'b0;
            delay_next  = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next  = ACTIVE;
                    active_next = 1'b1;
                end

                ACTIVE: begin
                    active_next = 1'b1;
                    if (collide_taken) begin
                        x_next = new_x;
                        if (RESPAWN_DELAY_FRAMES > 0) begin
                            state_next  = WAIT_RESPAWN;
                            active_next = 1'b0;
                            delay_next  = DCW'(RESPAWN_DELAY_FRAMES);
                        end else begin
                            pulse_next = 1'b1;
                        end
                    end
                end

                WAIT_RESPAWN: begin
                    // Only frame boundaries after the collision cycle count.
                    active_next = 1'b0;
                    if (bus.startOfFrame) begin
                        if (delay_reg <= DCW'(1)) begin
                            state_next  = ACTIVE;
                            active_next = 1'b1;
                            pulse_next  = 1'b1;
                            delay_next  = '0;
                        end else begin
                            delay_next = delay_reg - DCW'(1);
                        end
                    end
                end

                default: begin
                    state_next  = IDLE;
                    active_next = 1'b0;
                    delay_next  = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_reg  <= IDLE;
            x_reg      <= 11'(INIT_X);
            active_reg <= 1'b0;
            pulse_reg  <= 1'b0;
            delay_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            x_reg      <= x_next;
            active_reg <= active_next;
            pulse_reg  <= pulse_next;
            delay_reg  <= delay_next;
        end
    end

    // Free-running LFSR, advances in every state including IDLE.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

`ifdef TREE_SPAWN_SCORE_EN
    logic [SCORE_WIDTH-1:0] score_reg;

    // Saturating count of collisions that were accepted.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            score_reg <= '0;
        end else if (collide_taken && (score_reg != {SCORE_WIDTH{1'b1}})) begin
            score_reg <= score_reg + 1'b1;
        end
    end

    assign bus.treesPassed = score_reg;
`else
    assign bus.treesPassed = '0;
`endif

    assign bus.topLeftX     = $signed(x_reg);
    assign bus.objectActive = active_reg;
    assign bus.respawnPulse = pulse_reg;

endmodule

// File: tb/tb_tree_spawn_controller.sv
// tb_tree_spawn_controller: two controllers (30-frame delay and immediate
// respawn) driven by the same randomized stimulus. A reference model predicts
// each cycle's outputs and queues them; a monitor pops and compares.
module tb_tree_spawn_controller;

    localparam int          SW    = 8;
    localparam int          MAXX  = 539;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          SMAX  = (1 << SW) - 1;

    logic clk = 1'b0;
    logic resetN = 1'b0;

    always #5 clk = ~clk;

    tree_spawn_if #(.SCORE_WIDTH(SW)) bus_a ();
    tree_spawn_if #(.SCORE_WIDTH(SW)) bus_z ();

    tree_spawn_controller #(.RESPAWN_DELAY_FRAMES(30), .SCORE_WIDTH(SW)) dut_a (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus_a.master)
    );

    tree_spawn_controller #(.RESPAWN_DELAY_FRAMES(0), .SCORE_WIDTH(SW)) dut_z (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus_z.master)
    );

`ifdef TREE_SPAWN_SCORE_EN
    localparam bit SCORE_ON = 1'b1;
`else
    localparam bit SCORE_ON = 1'b0;
`endif

    // Reference model: what the tree looks like after each clock edge.
    typedef struct {
        int          x;
        bit          vis;
        bit          pulse;
        int          score;
        int          frames_left;   // hidden frames still to wait, 0 = not waiting
        bit          running;       // game has been seen enabled since last park
        logic [15:0] lfsr;
    } model_t;

    typedef struct {
        int k;
        int x;
        bit vis;
        bit pulse;
        int score;
    } exp_t;

    model_t m [2];
    int     dly [2] = '{30, 0};
    exp_t   q [$];

    int checks = 0;
    int errors = 0;
    int respawns_a = 0;
    int respawns_z = 0;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        if (v == 16'h0000) return SEED;
        if (v[0]) return (v >> 1) ^ 16'hB400;
        return v >> 1;
    endfunction

    function automatic int place(input logic [15:0] v);
        int c;
        c = int'(v) % 1024;
        return (c > MAXX) ? c - (MAXX + 1) : c;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    task automatic step(input int k, input bit rn, input bit en, input bit sof, input bit col);
        if (!rn) begin
            m[k].x = 270; m[k].vis = 0; m[k].pulse = 0; m[k].score = 0;
            m[k].frames_left = 0; m[k].running = 0; m[k].lfsr = SEED;
            return;
        end
        m[k].pulse = 0;
        if (!en) begin
            m[k].running = 0; m[k].vis = 0; m[k].frames_left = 0;
        end else if (!m[k].running) begin
            m[k].running = 1; m[k].vis = 1;
        end else if (m[k].frames_left > 0) begin
            if (sof) begin
                m[k].frames_left--;
                if (m[k].frames_left == 0) begin
                    m[k].vis = 1; m[k].pulse = 1;
                end
            end
        end else if (col) begin
            m[k].x = place(m[k].lfsr);
            if (m[k].score < SMAX) m[k].score++;
            if (dly[k] > 0) begin
                m[k].frames_left = dly[k]; m[k].vis = 0;
            end else begin
                m[k].pulse = 1;
            end
        end
        m[k].lfsr = lfsr_adv(m[k].lfsr);
    endtask

    // Apply one cycle of stimulus, predict the result, queue it, then wait
    // for the following falling edge.
    task automatic cycle(input bit rn, input bit en, input bit sof, input bit col);
        exp_t e;
        resetN = rn;
        bus_a.enable = en; bus_a.startOfFrame = sof; bus_a.edgeCollide = col;
        bus_z.enable = en; bus_z.startOfFrame = sof; bus_z.edgeCollide = col;
        for (int k = 0; k < 2; k++) begin
            step(k, rn, en, sof, col);
            e.k = k; e.x = m[k].x; e.vis = m[k].vis; e.pulse = m[k].pulse;
            e.score = SCORE_ON ? m[k].score : 0;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    // Monitor: after each rising edge, compare whatever the model queued.
    initial begin
        exp_t e;
        int ax, as_;
        bit av, ap;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.k == 0) begin
                    ax = int'(bus_a.topLeftX); av = bus_a.objectActive;
                    ap = bus_a.respawnPulse;   as_ = int'(bus_a.treesPassed);
                    if (ap) respawns_a++;
                    chk("x_d30", ax, e.x);
                    chk("active_d30", int'(av), int'(e.vis));
                    chk("pulse_d30", int'(ap), int'(e.pulse));
                    chk("score_d30", as_, e.score);
                end else begin
                    ax = int'(bus_z.topLeftX); av = bus_z.objectActive;
                    ap = bus_z.respawnPulse;   as_ = int'(bus_z.treesPassed);
                    if (ap) respawns_z++;
                    chk("x_d0", ax, e.x);
                    chk("active_d0", int'(av), int'(e.vis));
                    chk("pulse_d0", int'(ap), int'(e.pulse));
                    chk("score_d0", as_, e.score);
                end
                chk("x_in_range", int'(ax >= 0 && ax <= MAXX), 1);
            end
        end
    end

    // Stimulus.
    initial begin
        bit sof, col, en, rn;
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        $display("phase reset/idle done at %0t", $time);

        // Game running: frame every 4 cycles, frequent collisions.
        for (int i = 0; i < 3000; i++) begin
            sof = (i % 4) == 3;
            col = ($urandom_range(0, 7) == 0);
            if (i == 1500) begin
                dut_z.lfsr_reg <= 16'h0000;
                m[1].lfsr = 16'h0000;
                cycle(1, 1, sof, col);
                chk("lfsr_reload", int'(dut_z.lfsr_reg), int'(SEED));
                $display("lfsr deposit: after reload lfsr=%h", dut_z.lfsr_reg);
            end else begin
                cycle(1, 1, sof, col);
            end
        end
        $display("phase run done: score_d0 model=%0d dut=%0d respawns d30=%0d d0=%0d",
                 m[1].score, bus_z.treesPassed, respawns_a, respawns_z);
        chk("saturated_d0", int'(bus_z.treesPassed), SCORE_ON ? SMAX : 0);

        // Random enable drops, random frames, one reset mid-operation.
        for (int i = 0; i < 2000; i++) begin
            sof = ($urandom_range(0, 3) == 0);
            col = ($urandom_range(0, 5) == 0);
            en  = ($urandom_range(0, 31) != 0);
            rn  = !(i == 1000 || i == 1001);
            cycle(rn, en, sof, col);
        end
        $display("phase random done: respawns d30=%0d d0=%0d", respawns_a, respawns_z);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
